// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: grant codes, read-tracking
// FSM states and one-hot select bit positions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IMEM = 2'd1,
    GNT_DRD  = 2'd2,
    GNT_DWR  = 2'd3
  } grant_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } state_e;

  // Bit positions inside the one-hot select vector.
  localparam int unsigned SEL_IMEM = 0;
  localparam int unsigned SEL_DRD  = 1;
  localparam int unsigned SEL_DWR  = 2;

  function automatic grant_e sel_to_grant(input logic [2:0] sel);
    if (sel[SEL_DWR])       return GNT_DWR;
    else if (sel[SEL_DRD])  return GNT_DRD;
    else if (sel[SEL_IMEM]) return GNT_IMEM;
    else                    return GNT_NONE;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Priority selector: data write > data read > fetch, unless the
// starvation flag forces the fetch port to win.
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic       imem_req,
  input  logic       drd_req,
  input  logic       dwr_req,
  input  logic       starve,
  output logic [2:0] sel
);

  // One-hot grant from the eligible requests.
  always_comb begin
    sel = '0;
    if (starve && imem_req) sel[SEL_IMEM] = 1'b1;
    else if (dwr_req)       sel[SEL_DWR]  = 1'b1;
    else if (drd_req)       sel[SEL_DRD]  = 1'b1;
    else if (imem_req)      sel[SEL_IMEM] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter for fetch, data read and data write.
// Optional starvation guard for the fetch port: ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        imem_ready,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_valid,
  input  logic        dmem_rready,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rvalid,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_wvalid,
  output logic        mem_rready,
  output logic [29:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wready,
  output logic [29:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [1:0]  grant
);

  state_e     state, state_nxt;
  logic       wr_pend;
  logic [2:0] sel;
  logic       starve;
  logic       imem_elig, drd_elig, dwr_elig;
  logic       unused_bits;

  // Memory latency is one cycle, so a requester's response returns in the
  // cycle after its grant and that same cycle may already issue again;
  // nothing stays outstanding past the response. Gating with resetb keeps
  // every combinational output at zero while reset is held.
  assign imem_elig = imem_ready  & resetb;
  assign drd_elig  = dmem_rready & resetb;
  assign dwr_elig  = dmem_wready & resetb;

  assign unused_bits = ^{imem_addr[1:0], dmem_raddr[1:0], dmem_waddr[1:0],
                         (STARVE_LIMIT != 0)};

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Count cycles the fetch port waits while requesting; saturate at the limit.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      starve_cnt <= '0;
    else if (!imem_ready || sel[SEL_IMEM])
      starve_cnt <= '0;
    else if (starve_cnt != CNT_W'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  arb_prio_sel u_prio (
    .imem_req (imem_elig),
    .drd_req  (drd_elig),
    .dwr_req  (dwr_elig),
    .starve   (starve),
    .sel      (sel)
  );

  // Read-tracking state and write-completion flag.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      wr_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_pend <= sel[SEL_DWR];
    end
  end

  // Next state follows whichever read was granted this cycle.
  always_comb begin
    state_nxt = IDLE;
    if (sel[SEL_IMEM])     state_nxt = RD_I;
    else if (sel[SEL_DRD]) state_nxt = RD_D;
  end

  // Response steering and memory-port muxing from the granted requester.
  always_comb begin
    imem_valid  = (state == RD_I);
    dmem_rvalid = (state == RD_D);
    dmem_wvalid = wr_pend;
    imem_rdata  = imem_valid  ? mem_rdata : '0;
    dmem_rdata  = dmem_rvalid ? mem_rdata : '0;

    mem_rready = sel[SEL_IMEM] | sel[SEL_DRD];
    mem_raddr  = '0;
    if (sel[SEL_IMEM])     mem_raddr = imem_addr[31:2];
    else if (sel[SEL_DRD]) mem_raddr = dmem_raddr[31:2];

    mem_wready = sel[SEL_DWR];
    mem_waddr  = sel[SEL_DWR] ? dmem_waddr[31:2] : '0;
    mem_wdata  = sel[SEL_DWR] ? dmem_wdata       : '0;
    mem_wstrb  = sel[SEL_DWR] ? dmem_wstrb       : '0;

    grant = sel_to_grant(sel);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetb;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        dmem_rready;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        dmem_wready;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_wvalid;
  logic        mem_rready;
  logic [29:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wready;
  logic [29:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .dmem_rready (dmem_rready),
    .dmem_raddr  (dmem_raddr),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .dmem_wready (dmem_wready),
    .dmem_waddr  (dmem_waddr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_wvalid (dmem_wvalid),
    .mem_rready  (mem_rready),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .grant       (grant)
  );

  always #5 clk = ~clk;

  // Read-only memory with one cycle of latency.
  always @(posedge clk) begin
    if (mem_rready) mem_rdata <= mem[mem_raddr[5:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        rr;  logic [31:0] ra;
    logic        wr;  logic [31:0] wa; logic [31:0] wd; logic [3:0] ws;
    logic [1:0]  e_gnt;
    logic [29:0] e_raddr;
    logic [29:0] e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_ivalid; logic [31:0] e_irdata;
    logic        e_rvalid; logic [31:0] e_rdata;
    logic        e_wvalid;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_ready  = 1'b0; imem_addr  = 32'h0;
    dmem_rready = 1'b0; dmem_raddr = 32'h0;
    dmem_wready = 1'b0; dmem_waddr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
  endtask

  int wcnt, icnt, igr;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    mem[8] = 32'hDEADBEEF;
    mem[9] = 32'h12345678;

    //           ir ia            rr ra            wr wa            wd            ws    gnt  raddr  waddr          wdata         wstrb iv irdata        rv rdata         wv
    vecs[0] = '{1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 32'h0,        32'h0,        4'h0, 2'd1, 30'd4, 30'h0,        32'h0,        4'h0, 1'b1, 32'h00500093, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h0,        32'h0,        4'h0, 2'd2, 30'd8, 30'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8000001C, 32'h41,       4'h1, 2'd3, 30'd0, 30'h20000007, 32'h41,       4'h1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[3] = '{1'b1, 32'h10, 1'b1, 32'h24, 1'b0, 32'h0,        32'h0,        4'h0, 2'd2, 30'd9, 30'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 32'h40,       32'hA5A5A5A5, 4'hF, 2'd3, 30'd0, 30'h10,       32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[5] = '{1'b0, 32'h10, 1'b0, 32'h20, 1'b0, 32'h40,       32'h55,       4'h3, 2'd0, 30'd0, 30'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};

    // Reset: outputs zero even with requests present.
    resetb = 1'b0;
    idle_inputs();
    imem_ready = 1'b1; imem_addr = 32'h10;
    dmem_wready = 1'b1; dmem_waddr = 32'h40; dmem_wdata = 32'hFF; dmem_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst grant", 32'(grant), 32'd0);
    check("rst mem_rready", 32'(mem_rready), 32'd0);
    check("rst mem_wready", 32'(mem_wready), 32'd0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst valids", 32'({imem_valid, dmem_rvalid, dmem_wvalid}), 32'd0);
    check("rst imem_rdata", imem_rdata, 32'h0);
    @(negedge clk);
    idle_inputs();
    resetb = 1'b1;

    // Table-driven single transactions: grant cycle, then response cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_ready = vecs[i].ir; imem_addr = vecs[i].ia;
      dmem_rready = vecs[i].rr; dmem_raddr = vecs[i].ra;
      dmem_wready = vecs[i].wr; dmem_waddr = vecs[i].wa;
      dmem_wdata = vecs[i].wd; dmem_wstrb = vecs[i].ws;
      #1;
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d mem_rready", i), 32'(mem_rready),
            32'(vecs[i].e_gnt == 2'd1 || vecs[i].e_gnt == 2'd2));
      check($sformatf("v%0d mem_raddr", i), 32'(mem_raddr), 32'(vecs[i].e_raddr));
      check($sformatf("v%0d mem_wready", i), 32'(mem_wready), 32'(vecs[i].e_gnt == 2'd3));
      check($sformatf("v%0d mem_waddr", i), 32'(mem_waddr), 32'(vecs[i].e_waddr));
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_wstrb));
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("v%0d imem_valid", i), 32'(imem_valid), 32'(vecs[i].e_ivalid));
      check($sformatf("v%0d imem_rdata", i), imem_rdata, vecs[i].e_irdata);
      check($sformatf("v%0d dmem_rvalid", i), 32'(dmem_rvalid), 32'(vecs[i].e_rvalid));
      check($sformatf("v%0d dmem_rdata", i), dmem_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d dmem_wvalid", i), 32'(dmem_wvalid), 32'(vecs[i].e_wvalid));
      check($sformatf("v%0d resp grant", i), 32'(grant), 32'd0);
    end

    // Write and fetch together: write first, fetch next, one pulse each.
    @(negedge clk);
    wcnt = 0; icnt = 0;
    dmem_wready = 1'b1; dmem_waddr = 32'h8000001C; dmem_wdata = 32'h41; dmem_wstrb = 4'h1;
    imem_ready = 1'b1; imem_addr = 32'h10;
    #1;
    check("ww c0 grant", 32'(grant), 32'd3);
    check("ww c0 mem_waddr", 32'(mem_waddr), 32'h20000007);
    wcnt += int'(dmem_wvalid); icnt += int'(imem_valid);
    @(negedge clk);
    dmem_wready = 1'b0;
    #1;
    check("ww c1 grant", 32'(grant), 32'd1);
    check("ww c1 dmem_wvalid", 32'(dmem_wvalid), 32'd1);
    check("ww c1 mem_raddr", 32'(mem_raddr), 32'd4);
    wcnt += int'(dmem_wvalid); icnt += int'(imem_valid);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    check("ww c2 imem_valid", 32'(imem_valid), 32'd1);
    check("ww c2 imem_rdata", imem_rdata, 32'h00500093);
    check("ww c2 grant", 32'(grant), 32'd0);
    wcnt += int'(dmem_wvalid); icnt += int'(imem_valid);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      wcnt += int'(dmem_wvalid); icnt += int'(imem_valid);
    end
    check("ww wvalid pulses", 32'(wcnt), 32'd1);
    check("ww ivalid pulses", 32'(icnt), 32'd1);
    idle_inputs();

    // Continuous data reads against a held fetch request.
    @(negedge clk);
    igr = 0;
    dmem_rready = 1'b1; dmem_raddr = 32'h20;
    imem_ready = 1'b1; imem_addr = 32'h10;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("starve k%0d grant", k), 32'(grant),
            (GUARD && k == 5) ? 32'd1 : 32'd2);
      if (grant == 2'd1) igr++;
      @(negedge clk);
    end
    check("starve imem grants", 32'(igr), GUARD ? 32'd1 : 32'd0);
    idle_inputs();
    repeat (2) @(negedge clk);

    // Reset dropped in the response cycle of a data read.
    dmem_rready = 1'b1; dmem_raddr = 32'h20;
    #1;
    check("rr grant", 32'(grant), 32'd2);
    @(posedge clk);
    #1;
    dmem_rready = 1'b0;
    resetb = 1'b0;
    #1;
    check("rr rvalid in reset", 32'(dmem_rvalid), 32'd0);
    check("rr rdata in reset", dmem_rdata, 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("rr after c%0d", c), 32'({dmem_rvalid, imem_valid, dmem_wvalid}), 32'd0);
      @(negedge clk);
    end

    // Reset dropped right after a write grant.
    dmem_wready = 1'b1; dmem_waddr = 32'h40; dmem_wdata = 32'h1; dmem_wstrb = 4'h1;
    #1;
    check("rw grant", 32'(grant), 32'd3);
    @(posedge clk);
    #1;
    idle_inputs();
    resetb = 1'b0;
    #1;
    check("rw wvalid in reset", 32'(dmem_wvalid), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("rw after c%0d", c), 32'(dmem_wvalid), 32'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied instruction-request cycles before the instruction port is forced to win.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetb, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port imem_ready, input, 1 bit: fetch request, held asserted until imem_valid is seen.
REQ-005 SHALL have ports imem_addr (input, 32) and imem_rdata (output, 32): the fetch byte address and the returned instruction word.
REQ-006 SHALL have port imem_valid, output, 1 bit: a one-cycle pulse that qualifies imem_rdata.
REQ-007 SHALL have ports dmem_rready (input, 1), dmem_raddr (input, 32), dmem_rdata (output, 32) and dmem_rvalid (output, 1): the data-read request, address, data and one-cycle completion pulse.
REQ-008 SHALL have ports dmem_wready (input, 1), dmem_waddr (input, 32), dmem_wdata (input, 32), dmem_wstrb (input, 4) and dmem_wvalid (output, 1): the data-write request, address, data, byte strobes and one-cycle completion pulse.
REQ-009 SHALL have ports mem_rready (output, 1), mem_raddr (output, 30) and mem_rdata (input, 32): the shared memory read strobe, word address and data (memory read latency is 1 cycle).
REQ-010 SHALL have ports mem_wready (output, 1), mem_waddr (output, 30), mem_wdata (output, 32) and mem_wstrb (output, 4): the shared memory write port.
REQ-011 SHALL have port grant, output, 2 bits: the current-cycle owner (0 none, 1 imem, 2 dmem read, 3 dmem write).

Function
REQ-012 SHALL issue at most one memory operation per cycle; mem_* address, data and strobe outputs are driven combinationally from the granted requester, with addr[31:2] forming the word address.
REQ-013 SHALL use fixed priority dmem write > dmem read > imem, except as modified by REQ-018.
REQ-014 SHALL treat a requester as eligible only if its request is asserted and it has no transaction outstanding.
REQ-015 SHALL implement an FSM tracking the outstanding read, with states IDLE, RD_I and RD_D: any state moves to RD_I on an imem grant, to RD_D on a dmem read grant, and otherwise to IDLE.
REQ-016 In RD_I the arbiter SHALL assert imem_valid and pass mem_rdata to imem_rdata; in RD_D it SHALL assert dmem_rvalid and pass mem_rdata to dmem_rdata; imem_rdata and dmem_rdata SHALL be 0 when not valid.
REQ-017 SHALL pulse dmem_wvalid in the cycle after a write grant; a new grant SHALL be allowed in the same cycle a response returns (back-to-back throughput of 1 op/cycle).
REQ-018 SHALL maintain starve_cnt, which increments each cycle imem_ready is eligible but not granted, clears on an imem grant or when imem_ready deasserts, and saturates at STARVE_LIMIT; at STARVE_LIMIT the imem port SHALL win the next arbitration.
REQ-019 On simultaneous write and read requests, the write SHALL be granted first and the read in the following cycle.
REQ-020 When no request is eligible, the arbiter SHALL drive mem_rready = mem_wready = 0 and grant = 0.

Reset
REQ-021 While resetb = 0, all outputs SHALL be 0, the FSM SHALL be in IDLE and starve_cnt SHALL be 0.
REQ-022 On reset asserted mid-transaction, the outstanding read or write SHALL be dropped with no valid pulse after reset is released.

Configuration
REQ-023 When ARB_STARVE_GUARD_EN is defined, REQ-018 SHALL apply; when it is undefined, starve_cnt SHALL be absent and arbitration SHALL be pure fixed priority.

Structure
REQ-024 The grant encodings and FSM state encodings SHALL be placed in a shared package, mem_arb_pkg.
REQ-025 The priority and starvation decision SHALL be a sub-module, arb_prio_sel (combinational eligible requests plus starve flag in, one-hot grant out); the FSM and response steering SHALL stay in mem_arbiter.

Verification
REQ-026 Fetch only: imem_ready = 1 with imem_addr = 0x10 and mem[4] = 0x00500093 SHALL produce mem_raddr = 4 and, next cycle, imem_valid = 1 with imem_rdata = 0x00500093.
REQ-027 Write wins: dmem_wready and imem_ready asserted together SHALL give grant = 3 in cycle 0 and grant = 1 in cycle 1, with dmem_wvalid and imem_valid each pulsing exactly once.
REQ-028 Starvation: continuous dmem reads with imem_ready held and guard enabled SHALL give an imem grant in the 5th contended cycle (STARVE_LIMIT = 4); with the guard disabled, imem SHALL never be granted.
REQ-029 PUTC path: a write to 0x8000001C with wdata = 0x41 and wstrb = 0x1 SHALL produce mem_waddr = 0x20000007, mem_wdata = 0x41 and dmem_wvalid one cycle later.
REQ-030 Reset mid-read: resetb dropped in the cycle after a dmem read grant SHALL keep dmem_rvalid at 0 during reset and after resetb is released.
